crot_pi4_scheduler: RTL and testbench

CROT_PI4_SCHEDULER -- requirements
Module: crot_pi4_scheduler

---
 rtl/crot_pi4_scheduler.sv | 144 ++++++++++++++
 tb/tb_crot_pi4_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/crot_pi4_scheduler.sv
// crot_pi4_scheduler: round-robin shared pi/4 rotation pipeline with FWFT result FIFO (optional stats via CROT_SCHED_STATS_EN)
module crot_pi4_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int FRAC_W     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]    req_ar,
  input  logic [NUM_REQ*DATA_W-1:0]    req_ai,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [DATA_W-1:0]            res_pr,
  output logic [DATA_W-1:0]            res_pi,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  output logic                         busy
`ifdef CROT_SCHED_STATS_EN
  ,
  output logic [15:0]                  issue_cnt,
  output logic [15:0]                  stall_cnt
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int SW   = DATA_W + 1;
  localparam int PW   = 2 * DATA_W;
  localparam int EW   = ID_W + 2 * DATA_W;

  logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d, grant;
  logic                         any_req, can_issue, hs, push, pop;
  logic [CW:0]                  occ;
  logic [3:0]                   v_q, v_d;
  logic [3:0][ID_W-1:0]         id_q, id_d;
  logic signed [DATA_W-1:0]     s0_ar_q, s0_ar_d, s0_ai_q, s0_ai_d;
  logic signed [SW-1:0]         s1_dif_q, s1_dif_d, s1_sum_q, s1_sum_d;
  logic signed [PW-1:0]         s2_pd_q, s2_pd_d, s2_ps_q, s2_ps_d;
  logic signed [DATA_W-1:0]     s3_pr_q, s3_pr_d, s3_pi_q, s3_pi_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [EW-1:0]                mem_q [FIFO_DEPTH];
  logic [EW-1:0]                head;

  // Round-robin pick starting at rr_ptr; issue gated by total occupancy so the FIFO can never overflow
  always_comb begin
    grant   = rr_ptr_q;
    any_req = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant   = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        any_req = 1'b1;
      end
    end
    occ       = (CW+1)'(cnt_q) + (CW+1)'(v_q[0]) + (CW+1)'(v_q[1]) + (CW+1)'(v_q[2]) + (CW+1)'(v_q[3]);
    can_issue = occ < (CW+1)'(FIFO_DEPTH);
    req_ready = (!rst && can_issue && any_req) ? (NUM_REQ'(1) << grant) : '0;
    hs        = |(req_valid & req_ready);
    rr_ptr_d  = hs ? ((grant == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant + 1'b1)) : rr_ptr_q;
  end

  // Datapath: issue register, add/sub, multiply by 11, scale and truncate
  always_comb begin
    v_d      = {v_q[2:0], hs};
    id_d     = {id_q[2:0], grant};
    s0_ar_d  = $signed(req_ar[grant*DATA_W +: DATA_W]);
    s0_ai_d  = $signed(req_ai[grant*DATA_W +: DATA_W]);
    s1_dif_d = SW'(s0_ar_q) - SW'(s0_ai_q);
    s1_sum_d = SW'(s0_ar_q) + SW'(s0_ai_q);
    s2_pd_d  = PW'(s1_dif_q) * PW'(11);
    s2_ps_d  = PW'(s1_sum_q) * PW'(11);
    s3_pr_d  = DATA_W'(s2_pd_q >>> FRAC_W);
    s3_pi_d  = DATA_W'(s2_ps_q >>> FRAC_W);
  end

  // FIFO bookkeeping and output view; outputs forced quiet while in reset
  always_comb begin
    push      = v_q[3];
    res_valid = !rst && (cnt_q != '0);
    pop       = res_valid && res_ready;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    head      = res_valid ? mem_q[rd_ptr_q] : '0;
    {res_id, res_pr, res_pi} = head;
    busy      = !rst && ((|v_q) || (cnt_q != '0));
  end

  // State registers; data stages need no reset because valid bits qualify them
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      v_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      v_q      <= v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
    id_q     <= id_d;
    s0_ar_q  <= s0_ar_d;
    s0_ai_q  <= s0_ai_d;
    s1_dif_q <= s1_dif_d;
    s1_sum_q <= s1_sum_d;
    s2_pd_q  <= s2_pd_d;
    s2_ps_q  <= s2_ps_d;
    s3_pr_q  <= s3_pr_d;
    s3_pi_q  <= s3_pi_d;
  end

  // Result storage written from the last pipeline stage
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {id_q[3], s3_pr_q, s3_pi_q};
  end

`ifdef CROT_SCHED_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

  // Saturating accept and stall counters
  always_comb begin
    issue_cnt_d = (hs && issue_cnt_q != 16'hFFFF) ? issue_cnt_q + 16'd1 : issue_cnt_q;
    stall_cnt_d = ((|req_valid) && !hs && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    issue_cnt   = issue_cnt_q;
    stall_cnt   = stall_cnt_q;
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_crot_pi4_scheduler.sv
// tb_crot_pi4_scheduler: scoreboard bench for crot_pi4_scheduler (stats checked when CROT_SCHED_STATS_EN is defined)
module tb_crot_pi4_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_ar = '0;
  logic [N*W-1:0] req_ai = '0;
  logic           res_valid;
  logic           res_ready = 1'b1;
  logic [W-1:0]   res_pr, res_pi;
  logic [1:0]     res_id;
  logic           busy;
`ifdef CROT_SCHED_STATS_EN
  logic [15:0]    issue_cnt, stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int accepted = 0;
  logic [17:0] sb[$];
  logic [17:0] e, prev;
  logic        prev_stall = 1'b0;

  always #5 clk = ~clk;

  crot_pi4_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ar(req_ar), .req_ai(req_ai), .res_valid(res_valid), .res_ready(res_ready),
    .res_pr(res_pr), .res_pi(res_pi), .res_id(res_id), .busy(busy)
`ifdef CROT_SCHED_STATS_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] model(input int id, input logic signed [7:0] ar, input logic signed [7:0] ai);
    int d = ar - ai;
    int s = ar + ai;
    logic [7:0] pr = 8'((d * 11) >>> 4);
    logic [7:0] pi = 8'((s * 11) >>> 4);
    return {2'(id), pr, pi};
  endfunction

  // Monitor: pop and compare on every result handshake; record expected results on every request handshake
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
      chk("ready_in_reset", int'(req_ready), 0);
    end else begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = sb.pop_front();
          chk("res_id", int'(res_id), int'(e[17:16]));
          chk("res_pr", int'(res_pr), int'(e[15:8]));
          chk("res_pi", int'(res_pi), int'(e[7:0]));
        end
      end
      if (res_valid && !res_ready) begin
        if (prev_stall) chk("hold_stable", int'({res_id, res_pr, res_pi}), int'(prev));
        prev_stall = 1'b1;
      end else prev_stall = 1'b0;
      prev = {res_id, res_pr, res_pi};
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back(model(i, req_ar[i*W +: W], req_ai[i*W +: W]));
          accepted++;
        end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 100) begin step(1); n++; end
    chk("drain_idle", int'(busy), 0);
  endtask

  task automatic run_one(input int id, input int ar, input int ai, input int epr, input int epi);
    int n;
    req_ar[id*W +: W] = 8'(ar);
    req_ai[id*W +: W] = 8'(ai);
    req_valid = N'(1 << id);
    #1;
    chk("grant_single", int'(req_ready), 1 << id);
    step(1);
    req_valid = '0;
    n = 1;
    while (!res_valid && n < 20) begin step(1); n++; end
    chk("latency", n, 5);
    chk("direct_pr", int'($signed(res_pr)), epr);
    chk("direct_pi", int'($signed(res_pi)), epi);
    chk("direct_id", int'(res_id), id);
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    step(2);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_data", int'({res_id, res_pr, res_pi}), 0);
    rst = 1'b0;
    step(1);
    chk("idle_res_valid", int'(res_valid), 0);
    chk("idle_busy", int'(busy), 0);

    run_one(2, 16, 0, 11, 11);
    run_one(0, 16, 16, 0, 22);
    run_one(3, -16, 0, -11, -11);
    drain();

    // Fairness: rr_ptr is back at 0, all requesters contend
    for (int i = 0; i < N; i++) begin
      req_ar[i*W +: W] = 8'(20 * i - 30);
      req_ai[i*W +: W] = 8'(7 * i + 1);
    end
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_grant", int'(req_ready), 1 << (c % 4));
      step(1);
    end
    req_valid = '0;
    drain();

    // Backpressure: single requester, changing data every cycle
    res_ready = 1'b0;
    a0 = accepted;
    req_valid = 4'b0010;
    for (int c = 0; c < 30; c++) begin
      req_ar[W +: W] = 8'(c * 13 - 100);
      req_ai[W +: W] = 8'(c * 5 - 40);
      step(1);
    end
    chk("bp_accepted", accepted - a0, 8);
    chk("bp_ready_low", int'(req_ready), 0);
    chk("bp_res_valid", int'(res_valid), 1);
    res_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      req_ar[W +: W] = 8'(c * 29 + 3);
      req_ai[W +: W] = 8'(-c * 11);
      step(1);
    end
    chk("bp_resumed", int'(accepted - a0 > 8), 1);
    req_valid = '0;
    drain();

    // Reset with three ops in flight and two queued
    res_ready = 1'b0;
    a0 = accepted;
    req_valid = 4'b0100;
    step(5);
    req_valid = '0;
    step(1);
    chk("mid_accepted", accepted - a0, 5);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
    chk("post_rst_res_valid", int'(res_valid), 0);
    chk("post_rst_busy", int'(busy), 0);
    res_ready = 1'b1;
    step(12);
    chk("no_stale_valid", int'(res_valid), 0);

`ifdef CROT_SCHED_STATS_EN
    res_ready = 1'b0;
    req_valid = 4'b0001;
    step(12);
    req_valid = '0;
    res_ready = 1'b1;
    drain();
    req_valid = 4'b0001;
    step(2);
    req_valid = '0;
    chk("issue_cnt", int'(issue_cnt), 10);
    chk("stall_cnt", int'(stall_cnt), 4);
    drain();
`endif

    step(2);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
